// File: rtl/bcd_serial_addsub_pkg.sv
// rtl/bcd_serial_addsub_pkg.sv - shared types and BCD helpers for the serial decimal adder/subtractor
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  // Wraps for out-of-range digits so the result stays deterministic.
  function automatic logic [3:0] nines(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// rtl/bcd_serial_addsub_if.sv - operand/result handshake bundle for bcd_serial_addsub
interface bcd_serial_addsub_if #(
  parameter int DIGITS = 4
);
  logic                start;
  logic                sub;
  logic [4*DIGITS-1:0] A;
  logic [4*DIGITS-1:0] B;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] S;
  logic                Cout;
  logic                invalid;
  logic                neg;

  modport master (
    output start, sub, A, B,
    input  busy, done, S, Cout, invalid, neg
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, S, Cout, invalid, neg
  );
endinterface

// File: rtl/bcd_serial_addsub_digit_adder.sv
// rtl/bcd_serial_addsub_digit_adder.sv - one corrected BCD digit adder, shared by every serial step
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       bad
);
  logic [4:0] t;

  always_comb begin
    t   = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    bad = (a > BCD_MAX) || (b > BCD_MAX);
    if (t > {1'b0, BCD_MAX}) begin
      s    = t[3:0] + BCD_CORR;
      cout = 1'b1;
    end else begin
      s    = t[3:0];
      cout = 1'b0;
    end
  end
endmodule

// File: rtl/bcd_serial_addsub.sv
// rtl/bcd_serial_addsub.sv - digit-serial packed-BCD add/subtract, LSD first, start/busy/done
// Optional BCD_SIGNMAG_EN: negative differences are re-complemented to sign-magnitude.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  bcd_serial_addsub_if.slave bus
);
  localparam int            W    = 4 * DIGITS;
  localparam int            IW   = $clog2(DIGITS + 1);
  localparam logic [IW-1:0] LAST = IW'(DIGITS);

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx;
  logic          carry;
  logic          sub_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  s_q;
  logic          cout_q;
  logic          inv_q;
  logic [3:0]    op_a;
  logic [3:0]    op_b;
  logic [3:0]    dsum;
  logic          dcout;
  logic          dbad;
  logic          last;
  logic          busy;
  logic          done;
`ifdef BCD_SIGNMAG_EN
  logic          neg_q;
`endif

  // Each phase spends DIGITS cycles on digits plus one cycle to settle the final carry.
  assign last = (idx == LAST);

  always_comb begin
    op_a = a_q[3:0];
    op_b = sub_q ? nines(b_q[3:0]) : b_q[3:0];
`ifdef BCD_SIGNMAG_EN
    if (state == FIX) begin
      op_a = 4'd0;
      op_b = nines(s_q[3:0]);
    end
`endif
  end

  bcd_digit_adder u_digit (
    .a    (op_a),
    .b    (op_b),
    .cin  (carry),
    .s    (dsum),
    .cout (dcout),
    .bad  (dbad)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        if (last) begin
`ifdef BCD_SIGNMAG_EN
          state_nxt = (sub_q && !carry) ? FIX : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
      FIX:  if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == FIX);
    done = (state == DONE);
  end

  // Operands shift down one digit per step; result digits enter at the top so
  // digit 0 lands at S[3:0] after DIGITS steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx    <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      inv_q  <= 1'b0;
`ifdef BCD_SIGNMAG_EN
      neg_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            sub_q <= bus.sub;
            carry <= bus.sub;
            idx   <= '0;
            s_q   <= '0;
            inv_q <= 1'b0;
`ifdef BCD_SIGNMAG_EN
            neg_q <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (!last) begin
            s_q   <= {dsum, s_q[W-1:4]};
            a_q   <= a_q >> 4;
            b_q   <= b_q >> 4;
            carry <= dcout;
            inv_q <= inv_q | dbad;
            idx   <= idx + IW'(1);
          end else begin
            cout_q <= carry;
            carry  <= 1'b1;
            idx    <= '0;
          end
        end
`ifdef BCD_SIGNMAG_EN
        FIX: begin
          if (!last) begin
            s_q   <= {dsum, s_q[W-1:4]};
            carry <= dcout;
            idx   <= idx + IW'(1);
          end else begin
            neg_q  <= 1'b1;
            cout_q <= 1'b0;
            idx    <= '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.S       = s_q;
  assign bus.Cout    = cout_q;
  assign bus.invalid = inv_q;
`ifdef BCD_SIGNMAG_EN
  assign bus.neg     = neg_q;
`else
  assign bus.neg     = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb/tb_bcd_serial_addsub.sv - scoreboard bench for bcd_serial_addsub
module tb_bcd_serial_addsub;
  localparam int D = 4;
  localparam int W = 4 * D;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         inv;
    logic         neg;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_serial_addsub_if #(.DIGITS(D)) bus();

  bcd_serial_addsub #(.DIGITS(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pow10();
    int m = 1;
    for (int i = 0; i < D; i++) m = m * 10;
    return m;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Decimal-integer reference for well-formed operands; latency is relative to acceptance.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   m  = pow10();
    int   ia = bcd2int(a);
    int   ib = bcd2int(b);
    e.inv = 1'b0;
    e.neg = 1'b0;
    e.due = D + 1;
    if (!s) begin
      e.cout = (ia + ib) >= m;
      e.s    = int2bcd((ia + ib) % m);
    end else if (ia >= ib) begin
      e.cout = 1'b1;
      e.s    = int2bcd(ia - ib);
    end else begin
      e.cout = 1'b0;
`ifdef BCD_SIGNMAG_EN
      e.s    = int2bcd(ib - ia);
      e.neg  = 1'b1;
      e.due  = 2 * D + 2;
`else
      e.s    = int2bcd(ia - ib + m);
`endif
    end
    return e;
  endfunction

  function automatic exp_t fixed(input logic [W-1:0] s, input logic c, input logic inv);
    exp_t e;
    e.s    = s;
    e.cout = c;
    e.inv  = inv;
    e.neg  = 1'b0;
    e.due  = D + 1;
    return e;
  endfunction

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.sub   = s;
    bus.start = 1'b1;
    e.due     = e.due + cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    bus.sub   = ~s;
  endtask

  task automatic wait_done();
    logic got = 1'b0;
    for (int i = 0; i < 4 * D + 10 && !got; i++) begin
      @(negedge clk);
      got = bus.done;
    end
    chk("done_seen", got, 1'b1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e,
                       input bit poke);
    launch(a, b, s, e);
    if (poke) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_done();
  endtask

  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", bus.done, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("S", bus.S, mon_e.s);
        chk("Cout", bus.Cout, mon_e.cout);
        chk("invalid", bus.invalid, mon_e.inv);
        chk("neg", bus.neg, mon_e.neg);
        chk("latency", cyc, mon_e.due);
        chk("busy_at_done", bus.busy, 1'b0);
      end
    end
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_S", bus.S, '0);
    chk("rst_Cout", bus.Cout, 1'b0);
    chk("rst_invalid", bus.invalid, 1'b0);
    chk("rst_neg", bus.neg, 1'b0);
    bus.start = 1'b0;
    reset     = 1'b0;

    do_op(16'h1234, 16'h5678, 1'b0, fixed(16'h6912, 1'b0, 1'b0), 1'b0);
    do_op(16'h9999, 16'h0001, 1'b0, fixed(16'h0000, 1'b1, 1'b0), 1'b0);
    do_op(16'h5000, 16'h1234, 1'b1, fixed(16'h3766, 1'b1, 1'b0), 1'b0);
    do_op(16'h1234, 16'h5000, 1'b1, model(16'h1234, 16'h5000, 1'b1), 1'b0);
    do_op(16'h00A0, 16'h0000, 1'b0, fixed(16'h0100, 1'b0, 1'b1), 1'b0);
    do_op(16'h000F, 16'h0001, 1'b0, fixed(16'h0016, 1'b0, 1'b1), 1'b0);
    do_op(16'h5000, 16'h000C, 1'b1, fixed(16'h5004, 1'b1, 1'b1), 1'b0);
    do_op(16'h0000, 16'h0000, 1'b1, fixed(16'h0000, 1'b1, 1'b0), 1'b0);
    do_op(16'h4321, 16'h1111, 1'b0, model(16'h4321, 16'h1111, 1'b0), 1'b1);

    do_op(16'h9999, 16'h0001, 1'b0, fixed(16'h0000, 1'b1, 1'b0), 1'b0);
    launch(16'h1234, 16'h5678, 1'b0, model(16'h1234, 16'h5678, 1'b0));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_S", bus.S, '0);
    chk("abort_Cout", bus.Cout, 1'b0);
    repeat (D + 3) @(negedge clk);
    chk("abort_idle", bus.busy, 1'b0);
    do_op(16'h0815, 16'h0999, 1'b0, fixed(16'h1814, 1'b0, 1'b0), 1'b0);

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < D; i++) begin
        ra[4*i +: 4] = 4'($urandom_range(0, 9));
        rb[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      do_op(ra, rb, 1'(n % 2), model(ra, rb, 1'(n % 2)), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
